// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   size_t       : access size encoding carried on ReqSize (byte/half/word/dword)
//   state_t      : transaction FSM states
//   size_bytes() : byte count n (1,2,4,8) for a given access size
//   LSU_MEM_BYTES: default size of the attached data memory in bytes
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int unsigned LSU_MEM_BYTES = 65536;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    function automatic int unsigned size_bytes(input size_t sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the CPU-side request/response channels and the data-memory pins of
// the load/store unit.
//   Req*  : request channel (valid/ready), from the execute stage
//   Rsp*  : response channel (valid/ready), back to the execute stage
//   Mem*  : pins of the 64-bit big-endian data memory
// slave  : the load/store unit's view
// master : the environment's view (execute stage + memory)
// -----------------------------------------------------------------------------
interface lsu_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [63:0] ReqAddr;
    logic [63:0] ReqWData;

    logic        RspValid;
    logic        RspReady;
    logic [63:0] RspData;
    logic        RspError;

    logic [63:0] MemAddress;
    logic [63:0] MemWriteData;
    logic        MemEnableRead;
    logic        MemEnableWrite;
    logic [63:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
        input  RspReady, MemReadData,
        output ReqReady, RspValid, RspData, RspError,
        output MemAddress, MemWriteData, MemEnableRead, MemEnableWrite
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
        output RspReady, MemReadData,
        input  ReqReady, RspValid, RspData, RspError,
        input  MemAddress, MemWriteData, MemEnableRead, MemEnableWrite
    );

endinterface

// File: rtl/lsu_format.sv
// -----------------------------------------------------------------------------
// lsu_format
// Combinational big-endian formatting for sub-doubleword accesses.
//   i_size       : access size
//   i_signed     : sign-extend the load result (ignored for doublewords)
//   i_mem_rdata  : doubleword read from memory at the access address
//   i_wdata      : right-aligned store data
//   o_load_data  : top n bytes of i_mem_rdata, right-aligned and extended
//   o_store_word : low n bytes of i_wdata placed in the top n bytes, remaining
//                  bytes taken unchanged from i_mem_rdata
// -----------------------------------------------------------------------------
module lsu_format
    import lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic        i_signed,
    input  logic [63:0] i_mem_rdata,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load_data,
    output logic [63:0] o_store_word
);

    // Fill bit for the extension: the MSB of the accessed field is always
    // MemReadData[63] because the field sits at the lowest (leftmost) address.
    logic w_fill;
    assign w_fill = i_signed & i_mem_rdata[63];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_load_data  = i_mem_rdata;
        o_store_word = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load_data  = {{56{w_fill}}, i_mem_rdata[63:56]};
                o_store_word = {i_wdata[7:0], i_mem_rdata[55:0]};
            end
            SZ_H: begin
                o_load_data  = {{48{w_fill}}, i_mem_rdata[63:48]};
                o_store_word = {i_wdata[15:0], i_mem_rdata[47:0]};
            end
            SZ_W: begin
                o_load_data  = {{32{w_fill}}, i_mem_rdata[63:32]};
                o_store_word = {i_wdata[31:0], i_mem_rdata[31:0]};
            end
            default: begin
                o_load_data  = i_mem_rdata;
                o_store_word = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Accepts one load/store at a
// time, range-checks the address, performs byte/half/word/doubleword accesses
// on a 64-bit big-endian memory (read-modify-write for narrow stores) and
// returns a response over a valid/ready channel.
//   Clock : system clock, all state on the rising edge
//   Reset : synchronous, active-high
//   bus   : lsu_if.slave -- Req*/Rsp* channels and Mem* pins
// Parameter MEM_BYTES: memory size; legal accesses need ReqAddr <= MEM_BYTES-8.
// All Rsp*/Mem* outputs and ReqReady come straight from registers.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic Clock,
    input  logic Reset,
    lsu_if.slave bus
);

    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    state_t      r_state;
    state_t      w_state_nxt;

    // Fields latched at accept
    logic        r_write;
    size_t       r_size;
    logic        r_signed;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    // Registered outputs
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [63:0] r_rsp_data;
    logic        r_rsp_error;
    logic [63:0] r_mem_wdata;
    logic        r_mem_rd_en;
    logic        r_mem_wr_en;

    logic        w_req_ready_nxt;
    logic        w_rsp_valid_nxt;
    logic        w_mem_rd_en_nxt;
    logic        w_mem_wr_en_nxt;

    logic        w_accept;
    logic        w_range_err;
    logic        w_rsp_done;
    logic [63:0] w_load_data;
    logic [63:0] w_store_word;

    // ReqReady is a register that is high only in IDLE, so it doubles as the
    // "idle" qualifier for acceptance.
    assign w_accept    = bus.ReqValid & r_req_ready;
    assign w_range_err = bus.ReqAddr > LAST_ADDR;
    assign w_rsp_done  = (r_state == RESP) & bus.RspReady;

    lsu_format u_format (
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_mem_rdata  (bus.MemReadData),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // State register
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_range_err) begin
                        w_state_nxt = RESP;
                    end else if (bus.ReqWrite && (size_t'(bus.ReqSize) == SZ_D)) begin
                        w_state_nxt = WR;
                    end else begin
                        w_state_nxt = RD;
                    end
                end
            end
            RD:      w_state_nxt = CAP;
            CAP:     w_state_nxt = r_write ? WR : RESP;
            WR:      w_state_nxt = RESP;
            RESP:    w_state_nxt = w_rsp_done ? IDLE : RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: decoded from the next state and registered below, so the
    // enables are flop outputs (glitch-free) and one-hot by construction.
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_mem_rd_en_nxt = (w_state_nxt == RD);
        w_mem_wr_en_nxt = (w_state_nxt == WR);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_req_ready <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_mem_rd_en <= w_mem_rd_en_nxt;
            r_mem_wr_en <= w_mem_wr_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_write     <= 1'b0;
            r_size      <= SZ_B;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_write     <= bus.ReqWrite;
                r_size      <= size_t'(bus.ReqSize);
                r_signed    <= bus.ReqSigned;
                r_addr      <= bus.ReqAddr;
                r_wdata     <= bus.ReqWData;
                r_rsp_data  <= '0;
                r_rsp_error <= w_range_err;
                // A doubleword store writes ReqWData as-is; narrow stores
                // overwrite this with the merged word in CAP.
                r_mem_wdata <= bus.ReqWData;
            end
            if (r_state == CAP) begin
                if (r_write) begin
                    r_mem_wdata <= w_store_word;
                end else begin
                    r_rsp_data  <= w_load_data;
                end
            end
        end
    end

    assign bus.ReqReady       = r_req_ready;
    assign bus.RspValid       = r_rsp_valid;
    assign bus.RspData        = r_rsp_data;
    assign bus.RspError       = r_rsp_error;
    assign bus.MemAddress     = r_addr;
    assign bus.MemWriteData   = r_mem_wdata;
    assign bus.MemEnableRead  = r_mem_rd_en;
    assign bus.MemEnableWrite = r_mem_wr_en;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the execute stage and drives the 64-bit big-endian byte-addressed data memory's Address/WriteData/EnableRead/EnableWrite/ReadData pins.
- Adds sub-doubleword accesses (byte/half/word; LDURB/LDURH/LDURSW/STURB/STURH) via extract-and-extend on loads and read-modify-write on stores.
- Also adds address range checking and a valid/ready handshake on both CPU-side channels.

Parameters:
- MEM_BYTES, 65536, size of the attached memory in bytes; a legal access needs ReqAddr <= MEM_BYTES-8.

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept a request this cycle
- ReqWrite  in  1  1=store, 0=load
- ReqSize  in  2  0=byte, 1=half, 2=word, 3=doubleword
- ReqSigned  in  1  sign-extend load result; ignored for stores and for size 3
- ReqAddr  in  64  byte address
- ReqWData  in  64  store data, right-aligned (low 8/16/32/64 bits used)
- RspValid  out  1  response present
- RspReady  in  1  consumer takes response
- RspData  out  64  load result, right-aligned and extended; 0 for stores and errors
- RspError  out  1  address out of range; no memory access was made
- MemAddress  out  64  to memory Address
- MemWriteData  out  64  to memory WriteData
- MemEnableRead  out  1  to memory EnableRead
- MemEnableWrite  out  1  to memory EnableWrite
- MemReadData  in  64  from memory ReadData; registered by memory, valid the cycle after EnableRead

Behaviour:
- Reset values: all outputs 0 except ReqReady=0 while Reset is high; state=IDLE.
- All Mem* outputs and Rsp* outputs are registered, with no combinational path from the Req inputs. Enables must be glitch-free and are never both 1.
- Request acceptance: ReqReady=1 only in IDLE. A request is accepted on an edge where ReqValid&&ReqReady. Accepted fields are latched; MemAddress holds the latched ReqAddr for the whole transaction.
- Range check at accept: ReqAddr > MEM_BYTES-8, comparing all 64 bits, gives error -> RESP with RspError=1 and RspData=0. No enable is raised.
- FSM states:
  - IDLE: on accept, go to RD for a load or a sub-doubleword store, WR for a doubleword store, RESP on error.
  - RD: MemEnableRead=1 for exactly one cycle -> CAP.
  - CAP: sample MemReadData.
    - Load: RspData <= extract -> RESP.
    - Store: MemWriteData <= merge -> WR.
  - WR: MemEnableWrite=1 for exactly one cycle -> RESP. For a doubleword store, MemWriteData=ReqWData.
  - RESP: RspValid=1, data held stable until RspValid&&RspReady, then IDLE. RspValid drops the cycle after the handshake.
- Cycles from the accept edge to RspValid high:
  - error: 1
  - doubleword store: 2
  - load: 3
  - sub-doubleword store: 4
- Back-to-back: the next request can be accepted the cycle after the response handshake.
- Big-endian rule, with n = 1,2,4,8 bytes:
  - Load extract: value = MemReadData[63 -: 8n], zero- or sign-extended to 64 bits.
  - Store merge: {ReqWData[8n-1:0], MemReadData[63-8n:0]}, so the bytes at Address+n..+7 are rewritten unchanged.
- Reset mid-transaction: state goes to IDLE at that edge and any pending response is dropped. Enables are 0 from the next cycle. A write whose WR cycle coincides with Reset still lands, because the memory has no reset; no response is given for it.
- RspReady is ignored outside RESP. ReqValid held high while busy is not accepted and must not alter the latched fields.

Decomposition:
- Package lsu_pkg contains:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - state enum (IDLE, RD, CAP, WR, RESP)
  - a function returning the byte count n from a size
  - the default MEM_BYTES
- One combinational sub-module, lsu_format:
  - inputs: size, signed, MemReadData, ReqWData
  - outputs: load result, merged store word
- FSM and registers stay in load_store_unit.

Test Plan:
- Doubleword store then load at 0x10, data 0x0123456789ABCDEF:
  - memory bytes 0x10..0x17 = 01,23,...,EF
  - store response at accept+2, load response at accept+3 with RspData=0x0123456789ABCDEF
- Preload 0x10..0x17 = 80,11,22,33,44,55,66,77:
  - LDURB unsigned -> 0x80
  - LDURB signed -> 0xFFFFFFFFFFFFFF80
  - LDURH signed -> 0xFFFFFFFFFFFF8011
  - LDURSW -> 0xFFFFFFFF80112233
- Same preload, STURB ReqWData=0xAA at 0x10:
  - one read cycle then one write cycle
  - doubleword load then returns 0xAA11223344556677
  - response at accept+4
- Range boundary, MEM_BYTES=65536:
  - addr 0xFFF8 -> succeeds
  - addr 0xFFF9 and 0x1_0000_0000 -> RspError=1 at accept+1, both enables stay 0 throughout
- Backpressure:
  - hold RspReady=0 for 5 cycles in RESP -> RspValid/RspData stable and ReqReady=0
  - a second ReqValid is not accepted until the cycle after the handshake
- Reset asserted in the CAP cycle of a byte store:
  - state goes to IDLE, no MemEnableWrite pulse, no response
  - memory bytes unchanged; ReqReady=1 the cycle after Reset falls
